// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding logic: the requesters and the external ALU.
interface alu_arbiter_if #(
   parameter int N   = 16,
   parameter int OPW = 4
);
   logic           req0_valid;
   logic           req0_ready;
   logic [N-1:0]   req0_a;
   logic [N-1:0]   req0_b;
   logic [OPW-1:0] req0_op;

   logic           req1_valid;
   logic           req1_ready;
   logic [N-1:0]   req1_a;
   logic [N-1:0]   req1_b;
   logic [OPW-1:0] req1_op;

   logic [N-1:0]   alu_a;
   logic [N-1:0]   alu_b;
   logic [OPW-1:0] alu_op;
   logic [N-1:0]   alu_out;

   logic           resp0_valid;
   logic           resp1_valid;
   logic [N-1:0]   resp_data;
   logic           resp_err;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output alu_a, alu_b, alu_op,
      input  alu_out,
      output resp0_valid, resp1_valid, resp_data, resp_err
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  alu_a, alu_b, alu_op,
      output alu_out,
      input  resp0_valid, resp1_valid, resp_data, resp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between two requesters.
// An accepted operation is registered onto the ALU inputs. The ALU is given
// one full cycle to settle. The result is then captured and returned to the
// owner with a one-cycle pulse. An opcode above 7 is answered with data 0
// and the error flag set.
module alu_arbiter #(
   parameter int N   = 16,
   parameter int OPW = 4
) (
   input logic clk,
   input logic rst,
   alu_arbiter_if.slave bus
);

   typedef enum logic {IDLE, EXEC} state_t;

   localparam logic [OPW-1:0] LAST_DEFINED_OP = OPW'(7);

   state_t         state;
   state_t         next_state;
   logic           last_grant;
   logic           owner;
   logic           err;
   logic           ready0;
   logic           ready1;
   logic           accept0;
   logic           accept1;
   logic [N-1:0]   alu_a_q;
   logic [N-1:0]   alu_b_q;
   logic [OPW-1:0] alu_op_q;
   logic [N-1:0]   resp_data_q;
   logic           resp_err_q;
   logic           resp0_q;
   logic           resp1_q;

   // Grant selection in IDLE: a lone requester wins, and a tie goes to the port that did not win last.
   always_comb begin
      next_state = state;
      ready0     = 1'b0;
      ready1     = 1'b0;
      if (state == IDLE && !rst) begin
         if (bus.req0_valid && bus.req1_valid) begin
            ready0 = last_grant;
            ready1 = !last_grant;
         end else begin
            ready0 = bus.req0_valid;
            ready1 = bus.req1_valid;
         end
      end
      accept0 = ready0 && bus.req0_valid;
      accept1 = ready1 && bus.req1_valid;
      case (state)
         IDLE:    if (accept0 || accept1) next_state = EXEC;
         EXEC:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register. A reset drops any operation that is in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Operand capture on acceptance, then result capture and response pulse when EXEC ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         err         <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         resp0_q     <= 1'b0;
         resp1_q     <= 1'b0;
      end else begin
         resp0_q <= 1'b0;
         resp1_q <= 1'b0;
         if (accept0) begin
            alu_a_q    <= bus.req0_a;
            alu_b_q    <= bus.req0_b;
            alu_op_q   <= bus.req0_op;
            err        <= (bus.req0_op > LAST_DEFINED_OP);
            owner      <= 1'b0;
            last_grant <= 1'b0;
         end else if (accept1) begin
            alu_a_q    <= bus.req1_a;
            alu_b_q    <= bus.req1_b;
            alu_op_q   <= bus.req1_op;
            err        <= (bus.req1_op > LAST_DEFINED_OP);
            owner      <= 1'b1;
            last_grant <= 1'b1;
         end
         if (state == EXEC) begin
            resp_data_q <= err ? '0 : bus.alu_out;
            resp_err_q  <= err;
            resp0_q     <= !owner;
            resp1_q     <= owner;
         end
      end
   end

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.resp0_valid = resp0_q;
   assign bus.resp1_valid = resp1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
// A behavioural ALU drives alu_out. Every cycle, a transaction-level model
// predicts the ready outputs, the response pulses and the held result. It
// also predicts the registered ALU inputs. Directed scenarios come first,
// followed by a randomized traffic phase.
module tb_alu_arbiter;

   localparam int N   = 16;
   localparam int OPW = 4;

   logic clk = 1'b0;
   logic rst;

   alu_arbiter_if #(.N(N), .OPW(OPW)) bus ();

   alu_arbiter #(.N(N), .OPW(OPW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Reference ALU. An undefined opcode returns a marker value that the arbiter must discard.
   function automatic logic [N-1:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [OPW-1:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a ^ b;
         4'd2:    return a | b;
         4'd3:    return a & b;
         4'd4:    return (a == b) ? 16'd1 : 16'd0;
         4'd5:    return (a < b) ? 16'd1 : 16'd0;
         4'd6:    return a << b[3:0];
         4'd7:    return a >> b[3:0];
         default: return 16'hDEAD;
      endcase
   endfunction

   // External ALU, combinational from the registered operands.
   assign bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pulses   = 0;
   int created  = 0;
   int grants[$];

   // Requester-side pending operations: held valid until they are granted.
   logic           p_v  [2];
   logic [N-1:0]   p_a  [2];
   logic [N-1:0]   p_b  [2];
   logic [OPW-1:0] p_op [2];

   // Transaction-level model state.
   int             free_at;
   int             m_last;
   logic           pend_v;
   int             pend_due;
   int             pend_port;
   logic [N-1:0]   pend_data;
   logic           pend_err;
   logic [N-1:0]   h_data;
   logic           h_err;
   logic [N-1:0]   m_a;
   logic [N-1:0]   m_b;
   logic [OPW-1:0] m_op;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset();
      free_at = cyc + 1;
      m_last  = 1;
      pend_v  = 1'b0;
      h_data  = '0;
      h_err   = 1'b0;
      m_a     = '0;
      m_b     = '0;
      m_op    = '0;
   endtask

   task automatic applyStimulus();
      bus.req0_valid = p_v[0];
      bus.req0_a     = p_a[0];
      bus.req0_b     = p_b[0];
      bus.req0_op    = p_op[0];
      bus.req1_valid = p_v[1];
      bus.req1_a     = p_a[1];
      bus.req1_b     = p_b[1];
      bus.req1_op    = p_op[1];
   endtask

   task automatic setOp(input int w, input logic [OPW-1:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b);
      p_v[w]  = 1'b1;
      p_op[w] = op;
      p_a[w]  = a;
      p_b[w]  = b;
      created++;
   endtask

   // One clock cycle: drive, compare against the model, advance the model, step the clock.
   task automatic cycle();
      logic e_r0, e_r1, e_p0, e_p1;
      int   w;
      applyStimulus();
      #1;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!rst && cyc >= free_at) begin
         if (p_v[0] && p_v[1]) begin
            if (m_last == 1) e_r0 = 1'b1;
            else             e_r1 = 1'b1;
         end else if (p_v[0]) e_r0 = 1'b1;
         else if (p_v[1])     e_r1 = 1'b1;
      end
      e_p0 = 1'b0;
      e_p1 = 1'b0;
      if (pend_v && pend_due == cyc) begin
         h_data = pend_data;
         h_err  = pend_err;
         if (pend_port == 0) e_p0 = 1'b1;
         else                e_p1 = 1'b1;
         pend_v = 1'b0;
      end
      checkOutput("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
      checkOutput("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
      checkOutput("resp0_valid", 32'(bus.resp0_valid), 32'(e_p0));
      checkOutput("resp1_valid", 32'(bus.resp1_valid), 32'(e_p1));
      checkOutput("resp_data", 32'(bus.resp_data), 32'(h_data));
      checkOutput("resp_err", 32'(bus.resp_err), 32'(h_err));
      checkOutput("alu_a", 32'(bus.alu_a), 32'(m_a));
      checkOutput("alu_b", 32'(bus.alu_b), 32'(m_b));
      checkOutput("alu_op", 32'(bus.alu_op), 32'(m_op));
      if (bus.resp0_valid === 1'b1 || bus.resp1_valid === 1'b1) pulses++;
      if (rst) begin
         modelReset();
      end else if (e_r0 || e_r1) begin
         w         = e_r0 ? 0 : 1;
         m_a       = p_a[w];
         m_b       = p_b[w];
         m_op      = p_op[w];
         pend_v    = 1'b1;
         pend_due  = cyc + 2;
         pend_port = w;
         pend_err  = (p_op[w] >= 8);
         pend_data = pend_err ? '0 : alu_ref(p_a[w], p_b[w], p_op[w]);
         free_at   = cyc + 2;
         m_last    = w;
         p_v[w]    = 1'b0;
         grants.push_back(w);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      for (int i = 0; i < 2; i++) begin
         p_v[i]  = 1'b0;
         p_a[i]  = '0;
         p_b[i]  = '0;
         p_op[i] = '0;
      end
      rst = 1'b1;
      applyStimulus();
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      free_at = 0;
      rst = 1'b0;

      $display("[TB] reset state and single ADD on port 0");
      cycle();
      setOp(0, 4'd0, 16'd3, 16'd4);
      cycle();
      checkOutput("t1_alu_op", 32'(bus.alu_op), 32'd0);
      checkOutput("t1_alu_a", 32'(bus.alu_a), 32'd3);
      cycle();
      checkOutput("t1_resp0_valid", 32'(bus.resp0_valid), 32'd1);
      checkOutput("t1_resp_data", 32'(bus.resp_data), 32'd7);
      checkOutput("t1_resp1_valid", 32'(bus.resp1_valid), 32'd0);
      cycle();
      cycle();

      $display("[TB] tie from reset");
      rst = 1'b1;
      setOp(0, 4'd1, 16'h00FF, 16'h0F0F);
      setOp(1, 4'd5, 16'hFFFF, 16'h0001);
      cycle();
      rst = 1'b0;
      cycle();
      cycle();
      checkOutput("t2_resp0_valid", 32'(bus.resp0_valid), 32'd1);
      checkOutput("t2_resp0_data", 32'(bus.resp_data), 32'h0FF0);
      cycle();
      cycle();
      checkOutput("t2_resp1_valid", 32'(bus.resp1_valid), 32'd1);
      checkOutput("t2_resp1_data", 32'(bus.resp_data), 32'h0000);
      cycle();
      cycle();

      $display("[TB] alternating grants with both ports busy");
      grants.delete();
      pulses  = 0;
      created = 0;
      for (int k = 0; k < 18; k++) begin
         for (int w = 0; w < 2; w++)
            if (!p_v[w] && created < 8)
               setOp(w, OPW'($urandom_range(0, 7)), N'($urandom), N'($urandom));
         cycle();
      end
      checkOutput("t3_grant_count", 32'(grants.size()), 32'd8);
      checkOutput("t3_pulse_count", 32'(pulses), 32'd8);
      for (int i = 0; i < grants.size(); i++)
         checkOutput("t3_grant_order", 32'(grants[i]), 32'(i % 2));

      $display("[TB] undefined opcode then SL on port 1");
      setOp(1, 4'd9, 16'h1234, 16'h0002);
      cycle();
      setOp(1, 4'd6, 16'd1, 16'd4);
      cycle();
      checkOutput("t4_err_valid", 32'(bus.resp1_valid), 32'd1);
      checkOutput("t4_err_flag", 32'(bus.resp_err), 32'd1);
      checkOutput("t4_err_data", 32'(bus.resp_data), 32'd0);
      cycle();
      cycle();
      checkOutput("t4_sl_data", 32'(bus.resp_data), 32'd16);
      checkOutput("t4_sl_err", 32'(bus.resp_err), 32'd0);
      cycle();

      $display("[TB] reset during EXEC");
      setOp(0, 4'd3, 16'hF0F0, 16'hFFFF);
      cycle();
      rst = 1'b1;
      setOp(0, 4'd0, 16'd10, 16'd20);
      setOp(1, 4'd0, 16'd30, 16'd40);
      cycle();
      checkOutput("t5_no_pulse", 32'(bus.resp0_valid), 32'd0);
      checkOutput("t5_alu_op", 32'(bus.alu_op), 32'd0);
      checkOutput("t5_alu_a", 32'(bus.alu_a), 32'd0);
      checkOutput("t5_alu_b", 32'(bus.alu_b), 32'd0);
      cycle();
      rst = 1'b0;
      grants.delete();
      cycle();
      checkOutput("t5_tie_winner", 32'(grants[0]), 32'd0);
      repeat (4) cycle();

      $display("[TB] back-to-back on port 0");
      setOp(0, 4'd4, 16'd5, 16'd5);
      cycle();
      setOp(0, 4'd7, 16'h8000, 16'd3);
      cycle();
      checkOutput("t6_seq_valid", 32'(bus.resp0_valid), 32'd1);
      checkOutput("t6_seq_data", 32'(bus.resp_data), 32'd1);
      grants.delete();
      cycle();
      checkOutput("t6_second_accept", 32'(grants.size()), 32'd1);
      cycle();
      checkOutput("t6_sr_valid", 32'(bus.resp0_valid), 32'd1);
      checkOutput("t6_sr_data", 32'(bus.resp_data), 32'h1000);
      cycle();

      $display("[TB] randomized traffic");
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 39) == 0);
         for (int w = 0; w < 2; w++) begin
            if (!p_v[w] && $urandom_range(0, 1) == 1) begin
               p_a[w] = N'($urandom);
               setOp(w, OPW'($urandom_range(0, 15)), p_a[w],
                     ($urandom_range(0, 3) == 0) ? p_a[w] : N'($urandom));
            end
         end
         cycle();
      end
      rst = 1'b0;
      repeat (8) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
